cnn_mul_pipe_rs: RTL and testbench

Parametrised, pipelined signed multiplier for the CNN datapath. It follows the single-cycle combinational DSP48 multipliers and adds:
- configurable pipeline depth, with a valid token and clock-enable stall;
- fixed-point rescale with round-half-up;
- optional saturation, with per-sample and sticky overflow flags.

It sits between the conv/fc operand fetch and the accumulator, so weight × activation products arrive already in accumulator format.

---
 rtl/cnn_mul_pkg.sv | 25 ++
 rtl/cnn_mul_pipe_rs_core.sv | 50 +++++
 rtl/cnn_mul_pipe_rs.sv | 141 ++++++++++++++
 tb/tb_cnn_mul_pipe_rs.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_mul_pkg.sv
// Shared sizing helpers and constants for the cnn_mul pipelined multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cnn_mul_pkg;

  // Legal pipeline depth; the top checks NUM_STAGE against this range during elaboration.
  localparam int NUM_STAGE_MIN = 1;
  localparam int NUM_STAGE_MAX = 6;

  // Exact signed product width for two signed operands.
  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1;
  endfunction

  // Largest value a signed dw-bit result can hold.
  function automatic longint sat_max(input int dw);
    return (longint'(1) <<< (dw - 1)) - longint'(1);
  endfunction

  // Smallest value a signed dw-bit result can hold.
  function automatic longint sat_min(input int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

endpackage

// File: rtl/cnn_mul_pipe_rs_core.sv
// Round-half-up rescale, range check and (with CNN_MUL_SAT_EN) clamp of a signed product.
// Latency: 0 cycles, purely combinational; sits in front of the final register.
// Backpressure: none; follows whatever drives p.
module cnn_mul_pipe_rs_core
  import cnn_mul_pkg::*;
#(
  parameter int P_WIDTH    = 24,
  parameter int DOUT_WIDTH = 25,
  parameter int FRAC_SHIFT = 0
) (
  input  logic signed [P_WIDTH-1:0]    p,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         ovf
);

  // One guard bit so adding the rounding half can never overflow.
  localparam int RW = P_WIDTH + 1;
  localparam logic signed [RW-1:0] MAX_R = RW'(sat_max(DOUT_WIDTH));
  localparam logic signed [RW-1:0] MIN_R = RW'(sat_min(DOUT_WIDTH));

  logic signed [RW-1:0] p_ext;
  logic signed [RW-1:0] r;

  assign p_ext = {p[P_WIDTH-1], p};

  generate
    if (FRAC_SHIFT > 0) begin : g_round
      // Adding half an LSB then flooring gives round-half-up (ties go toward +inf).
      localparam logic signed [RW-1:0] HALF = RW'(1) <<< (FRAC_SHIFT - 1);
      logic signed [RW-1:0] biased;
      assign biased = p_ext + HALF;
      assign r      = biased >>> FRAC_SHIFT;
    end else begin : g_no_round
      assign r = p_ext;
    end
  endgenerate

  // Flag out-of-range results and pick either the clamped bound or the wrapped low bits.
  always_comb begin
    ovf  = (r > MAX_R) || (r < MIN_R);
    dout = r[DOUT_WIDTH-1:0];
`ifdef CNN_MUL_SAT_EN
    if (ovf) begin
      if (r[RW-1]) dout = MIN_R[DOUT_WIDTH-1:0];
      else         dout = MAX_R[DOUT_WIDTH-1:0];
    end
`endif
  end

endmodule

// File: rtl/cnn_mul_pipe_rs.sv
// Pipelined signed multiplier with fixed-point rescale; CNN_MUL_SAT_EN enables output saturation.
// Latency: NUM_STAGE enabled (ce=1) cycles, one result per enabled cycle.
// Backpressure: none upstream; ce=0 freezes every stage, ovf_clr is ignored while stalled.
module cnn_mul_pipe_rs
  import cnn_mul_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int DIN0_WIDTH = 10,
  parameter int DIN1_WIDTH = 14,
  parameter int DOUT_WIDTH = 25,
  parameter int FRAC_SHIFT = 0
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         ce,
  input  logic                         din_vld,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic                         ovf_clr,
  output logic                         dout_vld,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         ovf,
  output logic                         ovf_sticky
);

  localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH);

  // Reject illegal configurations while elaborating.
  if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_stage
    $error("cnn_mul_pipe_rs: NUM_STAGE must lie in 1..6");
  end
  if (DOUT_WIDTH < 2 || DOUT_WIDTH > PW) begin : g_bad_dout
    $error("cnn_mul_pipe_rs: DOUT_WIDTH must not exceed DIN0_WIDTH+DIN1_WIDTH");
  end
  if (FRAC_SHIFT < 0 || FRAC_SHIFT > PW - 1 || ID < 0) begin : g_bad_misc
    $error("cnn_mul_pipe_rs: FRAC_SHIFT or ID out of range");
  end

  logic signed [PW-1:0]         core_p;
  logic signed [DOUT_WIDTH-1:0] core_dout;
  logic                         core_ovf;
  logic                         vld_last_in;
  logic                         ovf_set;
  logic [NUM_STAGE-1:0]         vld_q;
  logic [NUM_STAGE-1:0]         vld_next;

  generate
    if (NUM_STAGE == 1) begin : g_comb_in
      // Single stage: round/saturate works directly on the raw operands.
      assign core_p      = PW'(din0) * PW'(din1);
      assign vld_last_in = din_vld;
      assign vld_next    = din_vld;
    end else begin : g_pipe_in
      logic signed [DIN0_WIDTH-1:0] a_q;
      logic signed [DIN1_WIDTH-1:0] b_q;
      logic signed [PW-1:0]         prod;

      // Stage 1: capture the operand pair.
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ce) begin
          a_q <= din0;
          b_q <= din1;
        end
      end

      // Both operands are sign-extended to PW, so the truncated product is exact.
      assign prod        = PW'(a_q) * PW'(b_q);
      assign vld_last_in = vld_q[NUM_STAGE-2];
      assign vld_next    = {vld_q[NUM_STAGE-2:0], din_vld};

      if (NUM_STAGE == 2) begin : g_p_final
        assign core_p = prod;
      end else begin : g_p_dly
        logic signed [PW-1:0] p_q [NUM_STAGE-2];
        for (genvar s = 0; s < NUM_STAGE - 2; s++) begin : g_stage
          if (s == 0) begin : g_head
            // Stage 2: register the full product.
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
              if (!ap_rst_n) p_q[s] <= '0;
              else if (ce)   p_q[s] <= prod;
            end
          end else begin : g_tail
            // Middle stages only delay the product to reach the requested latency.
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
              if (!ap_rst_n) p_q[s] <= '0;
              else if (ce)   p_q[s] <= p_q[s-1];
            end
          end
        end
        assign core_p = p_q[NUM_STAGE-3];
      end
    end
  endgenerate

  cnn_mul_pipe_rs_core #(
    .P_WIDTH    (PW),
    .DOUT_WIDTH (DOUT_WIDTH),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_core (
    .p    (core_p),
    .dout (core_dout),
    .ovf  (core_ovf)
  );

  // Overflow only counts when it belongs to a real sample, never to a bubble.
  assign ovf_set = core_ovf & vld_last_in;

  // Valid token shift register; its last bit is dout_vld.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) vld_q <= '0;
    else if (ce)   vld_q <= vld_next;
  end

  assign dout_vld = vld_q[NUM_STAGE-1];

  // Final stage: rounded/saturated result and its per-sample overflow flag.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout <= '0;
      ovf  <= 1'b0;
    end else if (ce) begin
      dout <= core_dout;
      ovf  <= ovf_set;
    end
  end

  // Sticky overflow: a new overflow outranks a clear arriving in the same cycle.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (ce) begin
      if (ovf_set)      ovf_sticky <= 1'b1;
      else if (ovf_clr) ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cnn_mul_pipe_rs.sv
`timescale 1ns/1ps
module tb_cnn_mul_pipe_rs;

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  logic ce;
  logic din_vld;
  logic signed [9:0]  din0;
  logic signed [13:0] din1;
  logic ovf_clr;

  // Default configuration: 3 stages, no shift, 25-bit result.
  logic d_vld, d_ovf, d_sticky;
  logic signed [24:0] d_dout;
  // Rescale/overflow configuration: 2 stages, shift 4, 12-bit result.
  logic o_vld, o_ovf, o_sticky;
  logic signed [11:0] o_dout;
  // Rounding configuration: 1 stage, shift 1, 25-bit result.
  logic r_vld, r_ovf, r_sticky;
  logic signed [24:0] r_dout;

  int checks = 0;
  int errors = 0;

  always #5 ap_clk = ~ap_clk;

  cnn_mul_pipe_rs #(.ID(1), .NUM_STAGE(3), .DIN0_WIDTH(10), .DIN1_WIDTH(14),
                    .DOUT_WIDTH(25), .FRAC_SHIFT(0)) u_dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .din_vld(din_vld),
    .din0(din0), .din1(din1), .ovf_clr(ovf_clr),
    .dout_vld(d_vld), .dout(d_dout), .ovf(d_ovf), .ovf_sticky(d_sticky));

  cnn_mul_pipe_rs #(.ID(2), .NUM_STAGE(2), .DIN0_WIDTH(10), .DIN1_WIDTH(14),
                    .DOUT_WIDTH(12), .FRAC_SHIFT(4)) u_ovf (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .din_vld(din_vld),
    .din0(din0), .din1(din1), .ovf_clr(ovf_clr),
    .dout_vld(o_vld), .dout(o_dout), .ovf(o_ovf), .ovf_sticky(o_sticky));

  cnn_mul_pipe_rs #(.ID(3), .NUM_STAGE(1), .DIN0_WIDTH(10), .DIN1_WIDTH(14),
                    .DOUT_WIDTH(25), .FRAC_SHIFT(1)) u_rnd (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .din_vld(din_vld),
    .din0(din0), .din1(din1), .ovf_clr(ovf_clr),
    .dout_vld(r_vld), .dout(r_dout), .ovf(r_ovf), .ovf_sticky(r_sticky));

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drive(input logic v, input int a, input int b);
    din_vld = v;
    din0    = 10'(a);
    din1    = 14'(b);
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    ce = 1'b1; ovf_clr = 1'b0;
    drive(1'b0, 0, 0);
    tick(); tick();
    ap_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    ce = 1'b1; ovf_clr = 1'b0;
    drive(1'b1, 5, 5);
    #3;
    checks++; if (d_vld !== 1'b0)     begin errors++; $display("FAIL reset_vld got %b want 0", d_vld); end
    checks++; if (d_dout !== 25'sd0)  begin errors++; $display("FAIL reset_dout got %0d want 0", d_dout); end
    checks++; if (d_ovf !== 1'b0)     begin errors++; $display("FAIL reset_ovf got %b want 0", d_ovf); end
    checks++; if (d_sticky !== 1'b0)  begin errors++; $display("FAIL reset_sticky got %b want 0", d_sticky); end
    checks++; if (o_sticky !== 1'b0 || r_sticky !== 1'b0 || o_vld !== 1'b0 || r_vld !== 1'b0)
      begin errors++; $display("FAIL reset_others got %b%b%b%b want 0000", o_sticky, r_sticky, o_vld, r_vld); end
    tick();
    ap_rst_n = 1'b1;
    drive(1'b0, 0, 0);
    tick();
  endtask

  // -512 * 8191 = -4193792, fits 25 bits, appears exactly 3 cycles later.
  task automatic test_basic();
    do_reset();
    drive(1'b1, -512, 8191);
    tick();
    drive(1'b0, 0, 0);
    checks++; if (d_vld !== 1'b0) begin errors++; $display("FAIL basic_lat1 got %b want 0", d_vld); end
    tick();
    checks++; if (d_vld !== 1'b0) begin errors++; $display("FAIL basic_lat2 got %b want 0", d_vld); end
    tick();
    checks++; if (d_vld !== 1'b1) begin errors++; $display("FAIL basic_vld got %b want 1", d_vld); end
    checks++; if (d_dout !== -25'sd4193792) begin errors++; $display("FAIL basic_dout got %0d want -4193792", d_dout); end
    checks++; if (d_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", d_ovf); end
    tick();
    checks++; if (d_vld !== 1'b0) begin errors++; $display("FAIL basic_bubble got %b want 0", d_vld); end
  endtask

  task automatic test_back_to_back();
    int va [5] = '{-512,     511,     -512,    0,   7};
    int vb [5] = '{8191,     -8192,   -8192,   123, -3};
    int ve [5] = '{-4193792, -4186112, 4194304, 0,  -21};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 5) drive(1'b1, va[i], vb[i]);
      else       drive(1'b0, 0, 0);
      tick();
      if (i - 2 >= 0 && i - 2 < 5) begin
        checks++; if (d_vld !== 1'b1 || d_dout !== 25'(ve[i-2]))
          begin errors++; $display("FAIL b2b_%0d got vld=%b dout=%0d want vld=1 dout=%0d", i-2, d_vld, d_dout, ve[i-2]); end
      end else begin
        checks++; if (d_vld !== 1'b0) begin errors++; $display("FAIL b2b_idle_%0d got %b want 0", i, d_vld); end
      end
    end
  endtask

  // 511*8191 = 4185601; (4185601+8)>>>4 = 261600 -> low 12 bits 0xDE0 = -544.
  // -512*8191 = -4193792; (-4193784)>>>4 = -262112 -> low 12 bits 0x020 = 32.
  // 100*8 = 800; (808)>>>4 = 50, in range.
  task automatic test_overflow();
    int exp_pos, exp_neg;
`ifdef CNN_MUL_SAT_EN
    exp_pos = 2047; exp_neg = -2048;
`else
    exp_pos = -544; exp_neg = 32;
`endif
    do_reset();
    drive(1'b1, 511, 8191);
    tick();
    drive(1'b0, 0, 0);
    tick();
    checks++; if (o_vld !== 1'b1 || o_dout !== 12'(exp_pos))
      begin errors++; $display("FAIL ovf_pos_dout got vld=%b dout=%0d want vld=1 dout=%0d", o_vld, o_dout, exp_pos); end
    checks++; if (o_ovf !== 1'b1 || o_sticky !== 1'b1)
      begin errors++; $display("FAIL ovf_pos_flags got ovf=%b sticky=%b want 1 1", o_ovf, o_sticky); end
    tick();
    checks++; if (o_vld !== 1'b0 || o_ovf !== 1'b0 || o_sticky !== 1'b1)
      begin errors++; $display("FAIL ovf_bubble got vld=%b ovf=%b sticky=%b want 0 0 1", o_vld, o_ovf, o_sticky); end
    ce = 1'b0; ovf_clr = 1'b1;
    tick();
    checks++; if (o_sticky !== 1'b1) begin errors++; $display("FAIL ovf_clr_stalled got %b want 1", o_sticky); end
    ce = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (o_sticky !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", o_sticky); end
    drive(1'b1, -512, 8191);
    tick();
    drive(1'b0, 0, 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (o_sticky !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b want 1", o_sticky); end
    checks++; if (o_vld !== 1'b1 || o_ovf !== 1'b1 || o_dout !== 12'(exp_neg))
      begin errors++; $display("FAIL ovf_neg got vld=%b ovf=%b dout=%0d want 1 1 %0d", o_vld, o_ovf, o_dout, exp_neg); end
    drive(1'b1, 100, 8);
    tick();
    drive(1'b0, 0, 0);
    tick();
    checks++; if (o_vld !== 1'b1 || o_ovf !== 1'b0 || o_dout !== 12'sd50)
      begin errors++; $display("FAIL ovf_inrange got vld=%b ovf=%b dout=%0d want 1 0 50", o_vld, o_ovf, o_dout); end
  endtask

  // Single-stage, shift 1: 3->2, -3->-1, -5->-2, -1->0 (ties toward +inf).
  task automatic test_round();
    int ra [4] = '{3, -3, 5, -1};
    int rb [4] = '{1, 1, -1, 1};
    int re [4] = '{2, -1, -2, 0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ra[i], rb[i]);
      tick();
      checks++; if (r_vld !== 1'b1 || r_dout !== 25'(re[i]))
        begin errors++; $display("FAIL round_%0d got vld=%b dout=%0d want vld=1 dout=%0d", i, r_vld, r_dout, re[i]); end
    end
    drive(1'b0, 0, 0);
    tick();
    checks++; if (r_vld !== 1'b0 || r_ovf !== 1'b0)
      begin errors++; $display("FAIL round_bubble got vld=%b ovf=%b want 0 0", r_vld, r_ovf); end
  endtask

  // Alternating valid with a 2-cycle stall; expected pattern counted in enabled cycles.
  task automatic test_ce_stall();
    logic ce_t  [11] = '{1, 1, 1, 0,  0, 1, 1,  1, 1,   1, 1};
    logic vl_t  [11] = '{1, 0, 1, 1,  0, 0, 1,  0, 0,   0, 0};
    int   a_t   [11] = '{1, 0, 3, 99, 0, 0, -5, 0, 0,   0, 0};
    int   b_t   [11] = '{2, 0, 4, 99, 0, 0, 6,  0, 0,   0, 0};
    logic ev_t  [11] = '{0, 0, 1, 1,  1, 0, 1,  0, 1,   0, 0};
    int   ed_t  [11] = '{0, 0, 2, 2,  2, 0, 12, 0, -30, 0, 0};
    do_reset();
    for (int c = 0; c < 11; c++) begin
      ce = ce_t[c];
      drive(vl_t[c], a_t[c], b_t[c]);
      tick();
      checks++; if (d_vld !== ev_t[c]) begin errors++; $display("FAIL stall_vld_%0d got %b want %b", c, d_vld, ev_t[c]); end
      if (ev_t[c]) begin
        checks++; if (d_dout !== 25'(ed_t[c])) begin errors++; $display("FAIL stall_dout_%0d got %0d want %0d", c, d_dout, ed_t[c]); end
      end
    end
    ce = 1'b1;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    drive(1'b1, 1, 1); tick();
    drive(1'b1, 2, 2); tick();
    drive(1'b1, 3, 3); tick();
    drive(1'b1, 4, 4);
    checks++; if (d_vld !== 1'b1 || d_dout !== 25'sd1)
      begin errors++; $display("FAIL mid_pre got vld=%b dout=%0d want 1 1", d_vld, d_dout); end
    #2;
    ap_rst_n = 1'b0;
    #1;
    checks++; if (d_vld !== 1'b0 || d_dout !== 25'sd0 || d_ovf !== 1'b0 || d_sticky !== 1'b0)
      begin errors++; $display("FAIL mid_reset got vld=%b dout=%0d ovf=%b sticky=%b want 0 0 0 0", d_vld, d_dout, d_ovf, d_sticky); end
    drive(1'b0, 0, 0);
    tick();
    ap_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (d_vld !== 1'b0) begin errors++; $display("FAIL mid_release_%0d got %b want 0", i, d_vld); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_round();
    test_ce_stall();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
